// File: rtl/pfb_pkg.sv
// rtl/pfb_pkg.sv - shared types and constants for the PFB channel selector
package pfb_pkg;

   // Frame alignment state: SYNC until the first tlast is seen, then RUN
   typedef enum logic {
      SYNC = 1'b0,
      RUN  = 1'b1
   } state_t;

   // One complex sample: I in the low half, Q in the high half
   localparam int SAMPLE_W = 32;
   localparam int IQ_W     = 16;

endpackage : pfb_pkg

// File: rtl/pfb_lane_mux.sv
// rtl/pfb_lane_mux.sv - combinational LANES:1 sample multiplexer over a PFB beat
module pfb_lane_mux
   import pfb_pkg::*;
#(
   parameter int LANES = 8
) (
   input  logic [LANES*SAMPLE_W-1:0] data,
   input  logic [$clog2(LANES)-1:0]  sel,
   output logic [SAMPLE_W-1:0]       sample
);

   localparam int SW = $clog2(LANES);

   // Pick the lane whose index matches sel; zero if sel is out of range
   always_comb begin
      sample = '0;
      for (int k = 0; k < LANES; k++) begin
         if (sel == SW'(k)) begin
            sample = data[k*SAMPLE_W +: SAMPLE_W];
         end
      end
   end

endmodule : pfb_lane_mux

// File: rtl/pfb_chsel.sv
// rtl/pfb_chsel.sv - selects one channel per PFB frame; optional PFB_CHSEL_SYNC_ERR_EN framing check
module pfb_chsel
   import pfb_pkg::*;
#(
   parameter int N = 64,
   parameter int L = 4
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      s_axis_tvalid,
   input  logic                      s_axis_tlast,
   input  logic [2*L*SAMPLE_W-1:0]   s_axis_tdata,
   output logic                      m_axis_tvalid,
   output logic [SAMPLE_W-1:0]       m_axis_tdata,
   output logic [$clog2(N)-1:0]      m_axis_tuser,
   input  logic [31:0]               CHID_REG,
   output logic                      SYNC_ERR
);

   localparam int LANES = 2 * L;
   localparam int F     = N / LANES;
   localparam int LOGN  = $clog2(N);
   localparam int LW    = $clog2(LANES);
   localparam int CW    = (F > 1) ? $clog2(F) : 1;

   localparam logic [CW-1:0] LAST_BEAT = CW'(F - 1);

   state_t              state;
   state_t              state_nxt;
   logic [CW-1:0]       cnt;
   logic [LOGN-1:0]     chan_q;
   logic [LOGN-1:0]     chan_eff;
   logic [LOGN-1:0]     beat_full;
   logic [CW-1:0]       beat_sel;
   logic [LW-1:0]       lane_sel;
   logic                first_beat;
   logic                hit;
   logic [SAMPLE_W-1:0] lane_data;
   logic                unused_chid_bits;

   // Only the low LOGN bits of the channel register carry meaning
   assign unused_chid_bits = ^CHID_REG[31:LOGN];

   // A new channel request is taken on beat 0 and used on that same beat
   assign first_beat = (state == RUN) && s_axis_tvalid && (cnt == '0);
   assign chan_eff   = first_beat ? CHID_REG[LOGN-1:0] : chan_q;
   assign beat_full  = chan_eff >> LW;
   assign beat_sel   = beat_full[CW-1:0];
   assign lane_sel   = chan_eff[LW-1:0];

   pfb_lane_mux #(
      .LANES (LANES)
   ) u_lane_mux (
      .data   (s_axis_tdata),
      .sel    (lane_sel),
      .sample (lane_data)
   );

   // State register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= SYNC;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: leave SYNC on the first frame boundary, then stay in RUN
   always_comb begin
      state_nxt = state;
      case (state)
         SYNC:    if (s_axis_tvalid && s_axis_tlast) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = SYNC;
      endcase
   end

   // Output decode: the selected beat of an aligned frame produces a sample
   always_comb begin
      hit = 1'b0;
      if (state == RUN && s_axis_tvalid) begin
         hit = (cnt == beat_sel);
      end
   end

   // Beat counter: wraps at frame end, tlast always realigns it to zero
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt <= '0;
      end else if (s_axis_tvalid) begin
         if (state == SYNC || s_axis_tlast || cnt == LAST_BEAT) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Channel latch: mid-frame register writes wait for the next frame
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         chan_q <= '0;
      end else if (first_beat) begin
         chan_q <= CHID_REG[LOGN-1:0];
      end
   end

   // Output register: one-cycle valid pulse, data and index held otherwise
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= '0;
      end else begin
         m_axis_tvalid <= hit;
         if (hit) begin
            m_axis_tdata <= lane_data;
            m_axis_tuser <= chan_eff;
         end
      end
   end

`ifdef PFB_CHSEL_SYNC_ERR_EN
   logic frame_err;

   // Misplaced tlast, or a missing tlast on the last beat, is a framing error
   always_comb begin
      frame_err = 1'b0;
      if (state == RUN && s_axis_tvalid) begin
         frame_err = s_axis_tlast ? (cnt != LAST_BEAT) : (cnt == LAST_BEAT);
      end
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         SYNC_ERR <= 1'b0;
      end else if (frame_err) begin
         SYNC_ERR <= 1'b1;
      end
   end
`else
   assign SYNC_ERR = 1'b0;
`endif

endmodule : pfb_chsel
